// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO that serves as one vector lane's sample bank.
// Latency: a word written at edge k shows on dout_o after edge k; flags decode count with no lag.
// Backpressure: none (strobes only). Writes to a full FIFO are dropped unless a dequeue happens in the same cycle.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 50
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enq_i,
    input  logic                  deq_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  full_o_n,
    output logic                  empty_o_n
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  is_full;
    logic                  is_empty;
    logic                  do_enq;
    logic                  do_deq;

    // Wrap explicitly at FIFO_DEPTH-1 so non-power-of-two depths stay in range.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign is_full   = (count == CNT_W'(FIFO_DEPTH));
    assign is_empty  = (count == '0);
    assign do_enq    = enq_i & (~is_full | deq_i);
    assign do_deq    = deq_i & ~is_empty;

    assign dout_o    = mem[rd_ptr];
    assign full_o_n  = ~is_full;
    assign empty_o_n = ~is_empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_enq) begin
                mem[wr_ptr] <= din_i;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_deq) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_enq, do_deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus random traffic against a queue model.
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 50;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enq = 1'b0;
    logic          deq = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic          full_n;
    logic          empty_n;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q[$];

    sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .enq_i    (enq),
        .deq_i    (deq),
        .din_i    (din),
        .dout_o   (dout),
        .full_o_n (full_n),
        .empty_o_n(empty_n)
    );

    always #5 clk = ~clk;

    // One clock with the given strobes; model follows the FIFO rules on pre-edge occupancy.
    task automatic cycle(input logic e, input logic d, input logic [DW-1:0] v);
        int  n;
        bit  acc_e;
        bit  acc_d;
        enq = e;
        deq = d;
        din = v;
        n     = q.size();
        acc_e = e && (n != DEPTH || d);
        acc_d = d && (n != 0);
        @(posedge clk);
        #1;
        if (acc_d) void'(q.pop_front());
        if (acc_e) q.push_back(v);
        enq = 1'b0;
        deq = 1'b0;
    endtask

    task automatic do_reset(input logic e, input logic [DW-1:0] v);
        rst = 1'b1;
        enq = e;
        deq = 1'b1;
        din = v;
        @(posedge clk);
        #1;
        rst = 1'b0;
        enq = 1'b0;
        deq = 1'b0;
        q.delete();
    endtask

    task automatic test_reset;
        do_reset(1'b0, '0);
        checks++; if (empty_n !== 1'b0) begin errors++; $display("FAIL reset_empty got %b want 0", empty_n); end
        checks++; if (full_n !== 1'b1) begin errors++; $display("FAIL reset_full got %b want 1", full_n); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", dout); end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 8'hC3);
            checks++;
            if (empty_n !== 1'b0 || full_n !== 1'b1 || dout !== 8'h00) begin
                errors++;
                $display("FAIL underflow_%0d got empty_n=%b full_n=%b dout=%h want 0 1 00", i, empty_n, full_n, dout);
            end
        end
    endtask

    task automatic test_single;
        cycle(1'b1, 1'b0, 8'h5A);
        checks++; if (empty_n !== 1'b1) begin errors++; $display("FAIL single_empty got %b want 1", empty_n); end
        checks++; if (dout !== 8'h5A) begin errors++; $display("FAIL single_dout got %h want 5a", dout); end
        cycle(1'b0, 1'b1, 8'h00);
        checks++; if (empty_n !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", empty_n); end
    endtask

    task automatic test_fill;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (full_n !== 1'b1) begin errors++; $display("FAIL fill_early_full at %0d got %b want 1", i, full_n); end
            cycle(1'b1, 1'b0, DW'(i));
        end
        checks++; if (full_n !== 1'b0) begin errors++; $display("FAIL fill_full got %b want 0", full_n); end
        cycle(1'b1, 1'b0, 8'hFF);
        checks++; if (full_n !== 1'b0) begin errors++; $display("FAIL overflow_full got %b want 0", full_n); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (dout !== DW'(i) || empty_n !== 1'b1) begin
                errors++;
                $display("FAIL fill_order_%0d got dout=%h empty_n=%b want %h 1", i, dout, empty_n, DW'(i));
            end
            cycle(1'b0, 1'b1, 8'h00);
        end
        checks++; if (empty_n !== 1'b0) begin errors++; $display("FAIL fill_drained got %b want 0", empty_n); end
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0, DW'($urandom));
        for (int i = 0; i < 30; i++) begin
            checks++;
            if (dout !== q[0]) begin errors++; $display("FAIL wrap_pre_%0d got %h want %h", i, dout, q[0]); end
            cycle(1'b0, 1'b1, 8'h00);
        end
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, DW'(100 + i));
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (dout !== DW'(100 + i)) begin errors++; $display("FAIL wrap_order_%0d got %h want %h", i, dout, DW'(100 + i)); end
            cycle(1'b0, 1'b1, 8'h00);
        end
        checks++; if (empty_n !== 1'b0) begin errors++; $display("FAIL wrap_drained got %b want 0", empty_n); end
    endtask

    task automatic test_simultaneous;
        logic [DW-1:0] last;
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, DW'($urandom_range(0, 127)));
        cycle(1'b1, 1'b1, 8'hAA);
        checks++; if (full_n !== 1'b0) begin errors++; $display("FAIL simul_full got %b want 0", full_n); end
        checks++; if (dout !== q[0]) begin errors++; $display("FAIL simul_head got %h want %h", dout, q[0]); end
        last = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (dout !== q[0]) begin errors++; $display("FAIL simul_drain_%0d got %h want %h", i, dout, q[0]); end
            last = dout;
            cycle(1'b0, 1'b1, 8'h00);
        end
        checks++; if (last !== 8'hAA) begin errors++; $display("FAIL simul_last got %h want aa", last); end
        cycle(1'b1, 1'b1, 8'h11);
        checks++; if (empty_n !== 1'b1) begin errors++; $display("FAIL empty_both_empty got %b want 1", empty_n); end
        checks++; if (dout !== 8'h11) begin errors++; $display("FAIL empty_both_dout got %h want 11", dout); end
        cycle(1'b0, 1'b1, 8'h00);
        checks++; if (empty_n !== 1'b0) begin errors++; $display("FAIL empty_both_count got %b want 0", empty_n); end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, DW'(i + 1));
        do_reset(1'b1, 8'h77);
        checks++; if (empty_n !== 1'b0) begin errors++; $display("FAIL midrst_empty got %b want 0", empty_n); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL midrst_dout got %h want 00", dout); end
        cycle(1'b1, 1'b0, 8'h33);
        checks++; if (dout !== 8'h33) begin errors++; $display("FAIL midrst_enq got %h want 33", dout); end
        cycle(1'b0, 1'b1, 8'h00);
    endtask

    task automatic test_random;
        int pe;
        int pd;
        for (int i = 0; i < 3000; i++) begin
            pe = (i % 1000 < 500) ? 70 : 35;
            pd = (i % 1000 < 500) ? 35 : 70;
            cycle($urandom_range(0, 99) < pe, $urandom_range(0, 99) < pd, DW'($urandom));
            checks++;
            if (empty_n !== (q.size() != 0) || full_n !== (q.size() != DEPTH)) begin
                errors++;
                $display("FAIL rand_flags_%0d got empty_n=%b full_n=%b want occupancy %0d", i, empty_n, full_n, q.size());
            end
            if (q.size() != 0) begin
                checks++;
                if (dout !== q[0]) begin errors++; $display("FAIL rand_dout_%0d got %h want %h", i, dout, q[0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, synchronous first-in first-out buffer with first-word fall-through output.
- Used as a per-lane storage bank inside the convolution serial-in/parallel-out stage: one instance per vector lane, each holding up to one frame of samples.
- Writes and reads are single-cycle strobes with no handshake.
- Status is reported on active-low full and empty flags.

Parameters:
- DATA_WIDTH, 8, bit width of each stored word.
- FIFO_DEPTH, 50, number of words stored. Any integer >= 2 is legal; a power of two is not required.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous reset, active-high (one clock; reset is synchronous and active-high).
- enq_i  input  1  enqueue strobe; writes din_i this cycle.
- deq_i  input  1  dequeue strobe; pops the head word this cycle.
- din_i  input  DATA_WIDTH  write data.
- dout_o  output  DATA_WIDTH  current head word (combinational from storage at the read pointer).
- full_o_n  output  1  active-low full flag: 0 when count == FIFO_DEPTH, else 1.
- empty_o_n  output  1  active-low empty flag: 0 when count == 0, else 1.

Behaviour:
- Internal state:
  - write pointer and read pointer, each $clog2(FIFO_DEPTH) bits;
  - occupancy count, $clog2(FIFO_DEPTH+1) bits;
  - storage array of FIFO_DEPTH x DATA_WIDTH.
- Reset (rst_i=1 at a rising edge):
  - pointers and count go to 0;
  - all storage entries are cleared to 0;
  - after reset: dout_o=0, empty_o_n=0, full_o_n=1.
  - Reset overrides enq_i/deq_i in the same cycle.
  - Reset mid-operation discards all contents.
- Accept conditions, evaluated on the pre-edge state:
  - do_enq = enq_i & (count != FIFO_DEPTH | deq_i).
  - do_deq = deq_i & (count != 0).
- do_enq: storage[wr_ptr] <= din_i; wr_ptr advances by 1.
- do_deq: rd_ptr advances by 1.
- Pointer wrap: a pointer equal to FIFO_DEPTH-1 advances to 0, not to 2^N. Required for non-power-of-two depths.
- Count update: +1 on enq only, -1 on deq only, unchanged when both or neither occur.
- Full with enq_i=1 and deq_i=1: both operations succeed; count stays FIFO_DEPTH; the old head is popped and the new word is written.
- Full with enq_i=1 only: the write is dropped; storage, pointers and count are unchanged.
- Empty with deq_i=1: ignored. No pointer move, no underflow.
- Empty with enq_i=1 and deq_i=1: only the enqueue occurs (no bypass). Count becomes 1.
- Read latency (first-word fall-through):
  - dout_o = storage[rd_ptr] combinationally;
  - a word written at edge k is visible on dout_o after edge k when the FIFO was empty;
  - on a deq at edge k, the next word appears on dout_o after edge k.
- dout_o while empty shows the stale entry at rd_ptr. Consumers must qualify it with empty_o_n.
- Flags are combinational decodes of count. There is no registered lag; they update in the same cycle that count changes.
- Ordering: words leave in exactly the order accepted, with no duplication or loss except dropped overflow writes.

Test Plan:
- Reset:
  - after reset -> empty_o_n=0, full_o_n=1, dout_o=0;
  - deq_i=1 for 3 cycles -> flags unchanged, dout_o=0.
- Single word: enq din=0x5A for one cycle -> next cycle empty_o_n=1, dout_o=0x5A; deq one cycle -> empty_o_n=0.
- Fill (default depth 50): enq 0..49 -> full_o_n=0 after the 50th write; an extra enq of 0xFF is dropped; dequeue 50 times -> dout_o sequence is 0..49, then empty_o_n=0.
- Wrap-around: 30 enq, 30 deq, then 40 enq of 100..139 -> pointers wrap past 49; dequeue yields 100..139 in order.
- Simultaneous ops:
  - full + enq(0xAA) + deq -> count stays 50, head advances, 0xAA is last out;
  - empty + enq(0x11) + deq -> count 1, dout_o=0x11.
- Reset mid-operation: 10 words stored, assert rst_i one cycle -> empty_o_n=0, dout_o=0; a subsequent enq of 0x33 reads back 0x33.
